// File: rtl/spi_slave_pkg.sv
// Shared types for the SPI slave front-end: FSM states, command codes and
// the frame-header acceptance rule used when a frame completes.
package spi_slave_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // True when the received header is legal for the state that shifted it in.
    function automatic logic hdr_ok(input state_t st, input logic [1:0] cmd);
        logic ok;
        case (st)
            WRITE:     ok = (cmd == CMD_WR_ADDR) || (cmd == CMD_WR_DATA);
            READ_ADD:  ok = (cmd == CMD_RD_ADDR);
            READ_DATA: ok = (cmd == CMD_RD_DATA);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/spi_slave_param_if.sv
// SPI pins plus the parallel RAM-side handshake of the SPI slave front-end.
interface spi_slave_param_if #(
    parameter int DATA_W = 8
) ();
    logic              SS_n;
    logic              MOSI;
    logic              MISO;
    logic [DATA_W+1:0] rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              cmd_err;

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid, cmd_err
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid, cmd_err
    );
endinterface

// File: rtl/spi_tx_serializer.sv
// MSB-first parallel-to-serial converter for the MISO path; MISO rests at
// MISO_IDLE whenever no read data is being shifted.
module spi_tx_serializer #(
    parameter int   DATA_W    = 8,
    parameter logic MISO_IDLE = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_miso,
    output logic              o_busy,
    output logic              o_done
);
    localparam int CW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] r_shift;
    logic [CW-1:0]     r_cnt;
    logic              r_busy;
    logic              r_done;
    logic              r_miso;

    // Load on capture, then emit one bit per clock; done stays set until cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_miso  <= MISO_IDLE;
        end else if (i_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_miso  <= MISO_IDLE;
        end else if (i_load) begin
            r_shift <= i_data;
            r_cnt   <= CW'(DATA_W);
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_miso  <= MISO_IDLE;
        end else if (r_busy) begin
            r_miso  <= r_shift[DATA_W-1];
            r_shift <= r_shift << 1;
            r_cnt   <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end else begin
            r_miso <= MISO_IDLE;
        end
    end

    assign o_miso = r_miso;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: rtl/spi_slave_param.sv
// SPI slave front-end: deserialises {cmd, payload} frames for the RAM, checks
// the read command sequence, and returns RAM read data on MISO.
module spi_slave_param
    import spi_slave_pkg::*;
#(
    parameter int   DATA_W     = 8,
    parameter int   TX_TIMEOUT = 15,
    parameter logic MISO_IDLE  = 1'b0
) (
    input logic              clk,
    input logic              rst_n,
    spi_slave_param_if.slave bus
);
    localparam int W  = DATA_W + 2;
    localparam int CW = $clog2(W + 1);
    localparam int TW = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

    state_t        r_state;
    state_t        w_next_state;
    logic [W-2:0]  r_rx_shift;
    logic [CW-1:0] r_bit_cnt;
    logic          r_frame_done;
    logic          r_rd_addr_done;
    logic [W-1:0]  r_rx_data;
    logic          r_rx_valid;
    logic          r_cmd_err;
    logic          r_tx_wait;
    logic [TW-1:0] r_wait_cnt;

    logic          w_abort;
    logic          w_cmd_bit;
    logic          w_shift_en;
    logic          w_last;
    logic [W-1:0]  w_rx_word;
    logic          w_hdr_ok;
    logic          w_good;
    logic          w_bad;
    logic          w_wait;
    logic          w_tx_load;
    logic          w_timeout;
    logic          w_tx_busy;
    logic          w_tx_done;
    logic          w_miso;

    // Releasing SS_n anywhere outside IDLE abandons the frame; it also wins
    // over a final bit sampled on the same edge.
    assign w_abort    = (r_state != IDLE) && bus.SS_n;
    assign w_cmd_bit  = (r_state == CHK_CMD) && !bus.SS_n;
    assign w_shift_en = ((r_state == WRITE) || (r_state == READ_ADD) || (r_state == READ_DATA))
                        && !bus.SS_n && !r_frame_done;
    assign w_last     = w_shift_en && (r_bit_cnt == CW'(W - 1));
    assign w_rx_word  = {r_rx_shift, bus.MOSI};
    assign w_hdr_ok   = hdr_ok(r_state, w_rx_word[W-1 -: 2]);
    assign w_good     = w_last && w_hdr_ok;
    assign w_bad      = w_last && !w_hdr_ok;
    assign w_wait     = (r_state == READ_DATA) && r_tx_wait && !bus.SS_n && !w_tx_busy && !w_tx_done;
    assign w_tx_load  = w_wait && bus.tx_valid;
    assign w_timeout  = w_wait && !bus.tx_valid && (r_wait_cnt == TW'(TX_TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; the first header bit chooses write or read path.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (!bus.SS_n) begin
                    w_next_state = CHK_CMD;
                end else begin
                    w_next_state = IDLE;
                end
            end
            CHK_CMD: begin
                if (bus.SS_n) begin
                    w_next_state = IDLE;
                end else if (!bus.MOSI) begin
                    w_next_state = WRITE;
                end else if (r_rd_addr_done) begin
                    w_next_state = READ_DATA;
                end else begin
                    w_next_state = READ_ADD;
                end
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (bus.SS_n) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = r_state;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Frame capture, strobes, read sequencing and tx_valid timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_shift     <= '0;
            r_bit_cnt      <= '0;
            r_frame_done   <= 1'b0;
            r_rd_addr_done <= 1'b0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_cmd_err      <= 1'b0;
            r_tx_wait      <= 1'b0;
            r_wait_cnt     <= '0;
        end else if (w_abort) begin
            r_bit_cnt    <= '0;
            r_frame_done <= 1'b0;
            r_rx_valid   <= 1'b0;
            r_cmd_err    <= 1'b0;
            r_tx_wait    <= 1'b0;
            r_wait_cnt   <= '0;
        end else begin
            r_rx_valid <= w_good;
            r_cmd_err  <= w_bad || w_timeout;
            if (w_cmd_bit || w_shift_en) begin
                r_rx_shift <= {r_rx_shift[W-3:0], bus.MOSI};
                r_bit_cnt  <= r_bit_cnt + CW'(1);
            end
            if (w_last) begin
                r_frame_done <= 1'b1;
                r_rx_data    <= w_rx_word;
            end
            if (w_good && (r_state == READ_ADD)) begin
                r_rd_addr_done <= 1'b1;
            end
            if (w_good && (r_state == READ_DATA)) begin
                r_rd_addr_done <= 1'b0;
                r_tx_wait      <= 1'b1;
            end
            if (w_tx_load || w_timeout) begin
                r_tx_wait <= 1'b0;
            end else if (w_wait) begin
                r_wait_cnt <= r_wait_cnt + TW'(1);
            end
        end
    end

    spi_tx_serializer #(
        .DATA_W    (DATA_W),
        .MISO_IDLE (MISO_IDLE)
    ) u_tx_serializer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_abort),
        .i_load  (w_tx_load),
        .i_data  (bus.tx_data),
        .o_miso  (w_miso),
        .o_busy  (w_tx_busy),
        .o_done  (w_tx_done)
    );

    assign bus.MISO     = w_miso;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.cmd_err  = r_cmd_err;

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param at DATA_W=8 and DATA_W=16 with a strobe scoreboard.
module tb_spi_slave_param;
    import spi_slave_pkg::*;

    typedef struct {
        logic        err;
        logic [17:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    exp_t q8[$];
    exp_t q16[$];
    bit   prev8 = 1'b0;
    bit   prev16 = 1'b0;

    always #5 clk = ~clk;

    spi_slave_param_if #(.DATA_W(8))  if8 ();
    spi_slave_param_if #(.DATA_W(16)) if16 ();

    spi_slave_param #(.DATA_W(8), .TX_TIMEOUT(15), .MISO_IDLE(1'b0)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .bus(if8)
    );
    spi_slave_param #(.DATA_W(16), .TX_TIMEOUT(15), .MISO_IDLE(1'b0)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .bus(if16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ss(input bit s, input logic v);
        if (s) if16.SS_n = v; else if8.SS_n = v;
    endtask
    task automatic set_mosi(input bit s, input logic v);
        if (s) if16.MOSI = v; else if8.MOSI = v;
    endtask
    task automatic set_tx(input bit s, input logic v, input logic [15:0] d);
        if (s) begin if16.tx_valid = v; if16.tx_data = d; end
        else begin if8.tx_valid = v; if8.tx_data = d[7:0]; end
    endtask

    function automatic logic get_miso(input bit s);
        return s ? if16.MISO : if8.MISO;
    endfunction
    function automatic logic get_rxv(input bit s);
        return s ? if16.rx_valid : if8.rx_valid;
    endfunction
    function automatic logic get_err(input bit s);
        return s ? if16.cmd_err : if8.cmd_err;
    endfunction
    function automatic logic [17:0] get_rxd(input bit s);
        return s ? if16.rx_data : {8'b0, if8.rx_data};
    endfunction
    function automatic logic get_rad(input bit s);
        return s ? u_dut16.r_rd_addr_done : u_dut8.r_rd_addr_done;
    endfunction
    function automatic state_t get_state(input bit s);
        return s ? u_dut16.r_state : u_dut8.r_state;
    endfunction

    task automatic push(input bit s, input logic err, input logic [17:0] d);
        exp_t e;
        e.err  = err;
        e.data = d;
        if (s) q16.push_back(e); else q8.push_back(e);
    endtask

    // Scoreboard side: every strobe must match the oldest pending expectation.
    task automatic mon(input bit s);
        logic rv;
        logic ce;
        int   n;
        exp_t e;
        rv = get_rxv(s);
        ce = get_err(s);
        if (rv || ce) begin
            n = s ? q16.size() : q8.size();
            check("strobe_exclusive", 32'(rv & ce), 32'd0);
            check("strobe_back_to_back", 32'(s ? prev16 : prev8), 32'd0);
            check("sb_pending", 32'(n > 0), 32'd1);
            if (n > 0) begin
                if (s) e = q16.pop_front(); else e = q8.pop_front();
                check("sb_kind", 32'(ce), 32'(e.err));
                check("sb_data", 32'(get_rxd(s)), 32'(e.data));
            end
        end
        if (s) prev16 = rv || ce; else prev8 = rv || ce;
    endtask

    always @(negedge clk) begin
        mon(1'b0);
        mon(1'b1);
    end

    // Drive one frame; cut < frame length raises SS_n in place of bit 'cut'.
    task automatic frame(input bit s, input logic [17:0] word, input int cut, input logic exp_err);
        int nb = s ? 18 : 10;
        if (cut >= nb) push(s, exp_err, word);
        @(negedge clk);
        set_ss(s, 1'b0);
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            if (i == cut) begin
                set_ss(s, 1'b1);
                break;
            end
            set_mosi(s, word[nb-1-i]);
        end
        @(negedge clk);
        if (cut >= nb) begin
            check("frame_strobe", {30'd0, get_rxv(s), get_err(s)}, exp_err ? 32'd1 : 32'd2);
        end else begin
            check("abort_idle", 32'(get_state(s) == IDLE), 32'd1);
            check("abort_no_strobe", {30'd0, get_rxv(s), get_err(s)}, 32'd0);
        end
    endtask

    // Starts in the cycle rx_valid is visible; cut < width injects reset mid-shift.
    task automatic tx_return(input bit s, input int dly, input logic [15:0] txd, input int cut);
        int nb = s ? 16 : 8;
        repeat (dly) @(negedge clk);
        set_tx(s, 1'b1, txd);
        @(negedge clk);
        set_tx(s, 1'b0, 16'h0000);
        check("miso_before_shift", 32'(get_miso(s)), 32'd0);
        for (int k = 0; k < nb; k++) begin
            if (k == cut) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_async_miso", 32'(get_miso(s)), 32'd0);
                check("rst_async_rxv", 32'(get_rxv(s)), 32'd0);
                check("rst_async_err", 32'(get_err(s)), 32'd0);
                check("rst_async_rxd", 32'(get_rxd(s)), 32'd0);
                check("rst_async_rad", 32'(get_rad(s)), 32'd0);
                return;
            end
            @(negedge clk);
            check("miso_bit", 32'(get_miso(s)), 32'(txd[nb-1-k]));
        end
        @(negedge clk);
        check("miso_after_shift", 32'(get_miso(s)), 32'd0);
        set_tx(s, 1'b1, 16'hFFFF);
        repeat (2) @(negedge clk);
        check("miso_tx_valid_ignored", 32'(get_miso(s)), 32'd0);
        set_tx(s, 1'b0, 16'h0000);
        set_ss(s, 1'b1);
        @(negedge clk);
    endtask

    task automatic read_seq(input bit s, input logic [17:0] a, input logic [17:0] d,
                            input int dly, input logic [15:0] txd, input int cut);
        frame(s, a, 99, 1'b0);
        check("rd_addr_done_set", 32'(get_rad(s)), 32'd1);
        set_ss(s, 1'b1);
        @(negedge clk);
        frame(s, d, 99, 1'b0);
        check("rd_addr_done_clr", 32'(get_rad(s)), 32'd0);
        tx_return(s, dly, txd, cut);
    endtask

    initial begin
        rst_n = 1'b0;
        set_ss(1'b0, 1'b1); set_mosi(1'b0, 1'b0); set_tx(1'b0, 1'b0, 16'h0000);
        set_ss(1'b1, 1'b1); set_mosi(1'b1, 1'b0); set_tx(1'b1, 1'b0, 16'h0000);
        #12;
        for (int s = 0; s < 2; s++) begin
            check("reset_miso", 32'(get_miso(bit'(s))), 32'd0);
            check("reset_rxv", 32'(get_rxv(bit'(s))), 32'd0);
            check("reset_err", 32'(get_err(bit'(s))), 32'd0);
            check("reset_rxd", 32'(get_rxd(bit'(s))), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Write-address frame 00_1010_0101.
        frame(1'b0, 18'h000A5, 99, 1'b0);
        set_ss(1'b0, 1'b1);
        @(negedge clk);
        check("rx_valid_one_cycle", 32'(get_rxv(1'b0)), 32'd0);

        // Read address then read data, RAM answers C3 two cycles after rx_valid.
        read_seq(1'b0, 18'h00203, 18'h00355, 2, 16'h00C3, 99);

        // Read-data header without a prior read address.
        frame(1'b0, 18'h00301, 99, 1'b1);
        check("bad_hdr_routed_read_add", 32'(get_state(1'b0) == READ_ADD), 32'd1);
        check("bad_hdr_rad_kept", 32'(get_rad(1'b0)), 32'd0);
        set_ss(1'b0, 1'b1);
        @(negedge clk);

        // Abort after 5 payload bits, then a full write-data frame.
        frame(1'b0, 18'h0015A, 7, 1'b0);
        check("abort_rxd_kept", 32'(get_rxd(1'b0)), 32'h301);
        frame(1'b0, 18'h001F0, 99, 1'b0);
        set_ss(1'b0, 1'b1);
        @(negedge clk);

        // SS_n rises on the edge that would sample the final bit.
        frame(1'b0, 18'h0003C, 9, 1'b0);
        @(negedge clk);

        // Read-data with no tx_valid: timeout error on cycle 15.
        frame(1'b0, 18'h00201, 99, 1'b0);
        set_ss(1'b0, 1'b1);
        @(negedge clk);
        frame(1'b0, 18'h00302, 99, 1'b0);
        push(1'b0, 1'b1, 18'h00302);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            check("timeout_miso_idle", 32'(get_miso(1'b0)), 32'd0);
            check("timeout_err", 32'(get_err(1'b0)), 32'(c == 15));
        end
        set_tx(1'b0, 1'b1, 16'h00FF);
        repeat (2) @(negedge clk);
        check("timeout_tx_ignored", 32'(get_miso(1'b0)), 32'd0);
        set_tx(1'b0, 1'b0, 16'h0000);
        set_ss(1'b0, 1'b1);
        @(negedge clk);

        // Reset asserted after three read-data bits have been shifted.
        read_seq(1'b0, 18'h00207, 18'h00300, 1, 16'h00A5, 3);
        set_ss(1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Wider frames on the DATA_W=16 instance.
        frame(1'b1, 18'h01234, 99, 1'b0);
        set_ss(1'b1, 1'b1);
        @(negedge clk);
        read_seq(1'b1, 18'h20003, 18'h3BEEF, 2, 16'hC3A5, 99);

        repeat (3) @(negedge clk);
        check("sb_drained_8", q8.size(), 32'd0);
        check("sb_drained_16", q16.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
